// File: rtl/sram_controller.sv
// Sequences a 32-bit word load/store as two 16-bit asynchronous SRAM accesses.
// ready stays low while an access is pending or in flight; the top level freezes on ~ready.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 5,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] WR_LO = 3'd3;
  localparam logic [2:0] WR_HI = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  logic [2:0]         state;
  logic [3:0]         cnt;
  logic [15:0]        lo_buf;
  logic [SRAM_AW-2:0] w;
  logic               last;

  // Out-of-range addresses simply wrap into the SRAM word space.
  assign w    = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
  assign last = (cnt == LAST);

  assign ready = (state == IDLE && !rd_en && !wr_en) ||
                 (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lo_buf    <= '0;
      read_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rd_en)      state <= RD_LO;
          else if (wr_en) state <= WR_LO;
        end
        RD_LO: begin
          if (last) begin
            state  <= RD_HI;
            cnt    <= '0;
            lo_buf <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_HI: begin
          if (last) begin
            state     <= DONE;
            cnt       <= '0;
            read_data <= {sram_dq_in, lo_buf};
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_LO: begin
          if (last) begin
            state <= WR_HI;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_HI: begin
          if (last) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Last cycle of each write phase is a hold cycle with the strobe released.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    unique case (state)
      RD_LO: sram_addr = {w, 1'b0};
      RD_HI: sram_addr = {w, 1'b1};
      WR_LO: begin
        sram_addr   = {w, 1'b0};
        sram_dq_out = write_data[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = last;
      end
      WR_HI: begin
        sram_addr   = {w, 1'b1};
        sram_dq_out = write_data[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM.
// Checks reset, phase timing, address mapping, priority and back-to-back loads.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  logic [15:0] mem [0:63];
  logic [31:0] last_rd;
  int          n_chk = 0;
  int          n_pass = 0;

  sram_controller #(
    .BASE_ADDR(1024), .WAIT_CYCLES(5), .SRAM_AW(18)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr[5:0]];

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe)
      mem[sram_addr[5:0]] <= sram_dq_out;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Caller has set inputs in cycle 0 (IDLE); returns in DONE.
  task automatic run_acc(input bit         is_wr,
                         input logic [17:0] exp_a,
                         input logic [31:0] wd,
                         input logic [31:0] exp_rd,
                         input bit         hold);
    #1;
    chk("rdy_c0", 32'(ready), 32'd0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k <= 10) begin
        chk($sformatf("rdy_c%0d", k), 32'(ready), 32'd0);
        chk($sformatf("addr_c%0d", k), 32'(sram_addr),
            32'(k <= 5 ? exp_a : exp_a + 18'd1));
        chk($sformatf("rd_hold_c%0d", k), read_data, last_rd);
        if (is_wr) begin
          chk($sformatf("oe_c%0d", k), 32'(sram_dq_oe), 32'd1);
          chk($sformatf("dq_c%0d", k), 32'(sram_dq_out),
              32'(k <= 5 ? wd[15:0] : wd[31:16]));
          chk($sformatf("we_c%0d", k), 32'(sram_we_n),
              32'((k == 5 || k == 10) ? 1 : 0));
        end else begin
          chk($sformatf("oe_c%0d", k), 32'(sram_dq_oe), 32'd0);
          chk($sformatf("we_c%0d", k), 32'(sram_we_n), 32'd1);
        end
      end else begin
        chk("rdy_done", 32'(ready), 32'd1);
        chk("addr_done", 32'(sram_addr), 32'd0);
        if (!is_wr) last_rd = exp_rd;
        chk("rdata_done", read_data, last_rd);
      end
    end
    if (!hold) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    address = '0; write_data = '0; last_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_we", 32'(sram_we_n), 32'd1);
    chk("rst_dq", 32'(sram_dq_out), 32'd0);

    // Async reset mid-write, no clock edge in between
    tick();
    wr_en = 1'b1; address = 32'd1100; write_data = 32'hCAFEF00D;
    tick(); tick();
    chk("mw_oe", 32'(sram_dq_oe), 32'd1);
    chk("mw_we", 32'(sram_we_n), 32'd0);
    #2 rst = 1'b1; wr_en = 1'b0;
    #1;
    chk("mw_rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("mw_rst_we", 32'(sram_we_n), 32'd1);
    chk("mw_rst_dq", 32'(sram_dq_out), 32'd0);
    chk("mw_rst_addr", 32'(sram_addr), 32'd0);
    chk("mw_rst_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Store then load
    wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
    run_acc(1'b1, 18'd0, 32'hDEADBEEF, 32'h0, 1'b0);
    tick();
    chk("idle_ready", 32'(ready), 32'd1);
    chk("mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("mem1", 32'(mem[1]), 32'h0000DEAD);
    rd_en = 1'b1; address = 32'd1024;
    run_acc(1'b0, 18'd0, 32'h0, 32'hDEADBEEF, 1'b0);
    tick();

    // Address mapping
    rd_en = 1'b1; address = 32'd1036;
    run_acc(1'b0, 18'd6, 32'h0, 32'hA007A006, 1'b0);
    tick();
    rd_en = 1'b1; address = 32'd1037;
    run_acc(1'b0, 18'd6, 32'h0, 32'hA007A006, 1'b0);
    tick();

    // Read wins over write
    rd_en = 1'b1; wr_en = 1'b1;
    address = 32'd1028; write_data = 32'h12345678;
    run_acc(1'b0, 18'd2, 32'h0, 32'hA003A002, 1'b0);
    tick();
    chk("both_mem2", 32'(mem[2]), 32'h0000A002);
    chk("both_mem3", 32'(mem[3]), 32'h0000A003);

    // Back-to-back loads: DONE, one IDLE cycle, then RD_LO
    rd_en = 1'b1; address = 32'd1040;
    run_acc(1'b0, 18'd8, 32'h0, 32'hA009A008, 1'b1);
    address = 32'd1044;
    tick();
    chk("b2b_idle_addr", 32'(sram_addr), 32'd0);
    chk("b2b_idle_rdata", read_data, 32'hA009A008);
    run_acc(1'b0, 18'd10, 32'h0, 32'hA00BA00A, 1'b0);
    tick();

    // Reset during RD_HI
    rd_en = 1'b1; address = 32'd1036;
    repeat (7) tick();
    chk("mr_addr_hi", 32'(sram_addr), 32'd7);
    #2 rst = 1'b1; rd_en = 1'b0;
    #1;
    last_rd = 32'h0;
    chk("mr_rdata", read_data, 32'd0);
    chk("mr_ready", 32'(ready), 32'd1);
    chk("mr_addr", 32'(sram_addr), 32'd0);
    #2 rst = 1'b0;
    tick();
    rd_en = 1'b1; address = 32'd1048;
    run_acc(1'b0, 18'd12, 32'h0, 32'hA00DA00C, 1'b0);
    tick();
    chk("end_ready", 32'(ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle memory controller between the MEM stage and an external 16-bit asynchronous SRAM. It turns each 32-bit word load or store from the pipeline into two sequenced 16-bit SRAM accesses and drives `ready` low while the access is in flight, so the top level derives the pipeline `freeze` from `~ready`. It is the first block that makes `freeze` a real signal instead of a tied-off constant.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, 5: cycles per 16-bit half access; legal range 1..15.
- `SRAM_AW`, 18: SRAM address width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rd_en`  in  1  word load request from MEM stage.
- `wr_en`  in  1  word store request from MEM stage.
- `address`  in  32  byte address; bits [1:0] are ignored.
- `write_data`  in  32  store data.
- `read_data`  out  32  load data; holds the last completed read.
- `ready`  out  1  high when no access is pending or in flight.
- `sram_addr`  out  SRAM_AW  SRAM halfword address.
- `sram_dq_out`  out  16  write data to SRAM.
- `sram_dq_in`  in  16  read data from SRAM.
- `sram_dq_oe`  out  1  drive enable for the SRAM data bus.
- `sram_we_n`  out  1  SRAM write strobe, active low.

## Operation
- Word index: `w = (address - BASE_ADDR) >> 2`, truncated to SRAM_AW-1 bits. Low half is at `{w,0}`, high half at `{w,1}`. No range check is done; out-of-range addresses wrap.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE: if `rd_en`, go to RD_LO. Otherwise, if `wr_en`, go to WR_LO. Read wins when both are high; the write is dropped.
- Each of the LO/HI states lasts exactly WAIT_CYCLES cycles, timed by a 4-bit counter that is cleared on every state entry.
  - LO→HI and HI→DONE transitions happen at the end of the last cycle.
- `sram_addr` holds the phase address for the whole phase. It is 0 in IDLE and DONE.
- Read phases:
  - `sram_dq_oe=0`, `sram_we_n=1`.
  - `sram_dq_in` is sampled on the last cycle of each phase into an internal buffer: bits [15:0] in RD_LO, bits [31:16] in RD_HI.
  - `read_data` updates from the buffer on entry to DONE. It is never partially updated.
- Write phases:
  - `sram_dq_oe=1`.
  - `sram_dq_out` = `write_data[15:0]` in WR_LO and `write_data[31:16]` in WR_HI.
  - `sram_we_n=0` on every phase cycle except the last, which is a hold cycle with `sram_we_n=1`. With WAIT_CYCLES=1, `sram_we_n` stays 1; this setting is for read-only simulation.
- DONE: lasts one cycle, then unconditionally goes to IDLE. The request inputs, still held by the frozen pipeline, are ignored in DONE.
- `ready` is combinational: `(state==IDLE && !rd_en && !wr_en) || state==DONE`.
- Inputs must stay stable while `ready=0`. Changing them mid-access is not supported and gives undefined data.

## Timing
- Reset values: state IDLE, `read_data=0`, `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`, `sram_we_n=1`, counter 0. `ready` then follows the IDLE rule.
- Reset mid-access aborts immediately and returns the state to IDLE. A partial write may have reached SRAM; `read_data` is cleared.
- Request first seen in cycle 0, when the state is IDLE and `ready` drops in the same cycle:
  - cycles 1..WAIT_CYCLES are the LO phase;
  - the next WAIT_CYCLES cycles are the HI phase;
  - cycle 2·WAIT_CYCLES+1 is DONE, with `ready=1`.
- Freeze length is 2·WAIT_CYCLES+1 cycles; for the default, 11 cycles low plus DONE in cycle 11.
- `read_data` is valid from DONE onward and holds until the next read reaches DONE.
- A back-to-back request is seen in IDLE on the cycle after DONE. There is no idle gap beyond that one IDLE cycle.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs go to reset values with no clock edge; `ready=1` with no request.
- Write then read:
  - store 0xDEADBEEF at 1024 (WAIT_CYCLES=5) → `sram_addr` is 0 for 5 cycles with `sram_dq_out=0xBEEF`, then 1 for 5 cycles with 0xDEAD; `sram_we_n` is low 4 of 5 cycles per phase; `ready` is low 11 cycles.
  - load 1024 → `read_data=0xDEADBEEF` in DONE.
- Address mapping: load from 1036 → `sram_addr` goes 6 then 7. Load from 1037 → same as 1036.
- Simultaneous `rd_en=wr_en=1` at 1028 → read sequence only; `sram_we_n` stays 1 and the SRAM model contents are unchanged.
- Back-to-back: two loads held continuously → second access starts exactly 2 cycles after the first DONE (DONE, then IDLE); `read_data` changes only at each DONE.
- Reset mid-read during RD_HI → state IDLE, `read_data=0`; a following load completes correctly with full latency.
